// File: rtl/ok_wire_arith_pkg.sv
// Shared types and limits for the ok_wire_arith engine.
// Build option: OK_WIRE_ARITH_SAT_EN selects saturating instead of wrapping results.
package ok_wire_arith_pkg;

    typedef enum logic [1:0] {
        ModeAdd  = 2'b00,
        ModeSub  = 2'b01,
        ModeAcc  = 2'b10,
        ModeLoad = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

    localparam int unsigned NChMin    = 1;
    localparam int unsigned NChMax    = 16;
    localparam int unsigned WidthMin  = 8;
    localparam int unsigned WidthMax  = 32;

    // Channel index width; a single channel still needs a 1-bit counter.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ok_arith_lane.sv
// Shared WIDTH-bit add/sub lane with carry/borrow detection.
// Build option: OK_WIRE_ARITH_SAT_EN clamps results on overflow (ADD/ACC to all-ones, SUB to 0).
module ok_arith_lane
    import ok_wire_arith_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  mode_e              mode_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic [WIDTH-1:0]   acc_i,
    output logic [WIDTH-1:0]   res_o,
    output logic               ovf_o
);

    logic [WIDTH:0] ext;

    // Compute result with one extra bit; the top bit is carry (add) or borrow (sub).
    always_comb begin
        ext   = '0;
        res_o = a_i;
        ovf_o = 1'b0;
        unique case (mode_i)
            ModeAdd: begin
                ext   = {1'b0, a_i} + {1'b0, b_i};
                res_o = ext[WIDTH-1:0];
                ovf_o = ext[WIDTH];
            end
            ModeSub: begin
                ext   = {1'b0, a_i} - {1'b0, b_i};
                res_o = ext[WIDTH-1:0];
                ovf_o = ext[WIDTH];
            end
            ModeAcc: begin
                ext   = {1'b0, acc_i} + {1'b0, a_i};
                res_o = ext[WIDTH-1:0];
                ovf_o = ext[WIDTH];
            end
            ModeLoad: begin
                res_o = a_i;
                ovf_o = 1'b0;
            end
            default: begin
                res_o = a_i;
                ovf_o = 1'b0;
            end
        endcase
`ifdef OK_WIRE_ARITH_SAT_EN
        if (ovf_o) begin
            res_o = (mode_i == ModeSub) ? '0 : '1;
        end
`endif
    end

endmodule

// File: rtl/ok_wire_arith.sv
// N-channel serial arithmetic engine behind FrontPanel wires, start/busy/done handshake.
// Build option: OK_WIRE_ARITH_SAT_EN (saturating lane results); default build wraps.
module ok_wire_arith
    import ok_wire_arith_pkg::*;
#(
    parameter int unsigned N_CH  = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                    okClk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [1:0]              mode,
    input  logic [N_CH-1:0]         ch_mask,
    input  logic [N_CH*WIDTH-1:0]   op_a,
    input  logic [N_CH*WIDTH-1:0]   op_b,
    output logic [N_CH*WIDTH-1:0]   result,
    output logic [N_CH-1:0]         overflow,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned IdxW = idx_width(N_CH);

    if (N_CH < NChMin || N_CH > NChMax || WIDTH < WidthMin || WIDTH > WidthMax) begin : g_bad_cfg
        $error("ok_wire_arith: N_CH or WIDTH out of range");
    end

    state_e                  state_q, state_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    mode_e                   mode_q, mode_d;
    logic [N_CH-1:0]         mask_q, mask_d;
    logic [N_CH*WIDTH-1:0]   a_q, a_d;
    logic [N_CH*WIDTH-1:0]   b_q, b_d;
    logic [N_CH*WIDTH-1:0]   result_q, result_d;
    logic [N_CH-1:0]         ovf_q, ovf_d;

    logic [WIDTH-1:0]        lane_res;
    logic                    lane_ovf;

    // One lane shared by all channels; the index selects its operands.
    ok_arith_lane #(
        .WIDTH (WIDTH)
    ) u_lane (
        .mode_i (mode_q),
        .a_i    (a_q[idx_q*WIDTH +: WIDTH]),
        .b_i    (b_q[idx_q*WIDTH +: WIDTH]),
        .acc_i  (result_q[idx_q*WIDTH +: WIDTH]),
        .res_o  (lane_res),
        .ovf_o  (lane_ovf)
    );

    // Next-state: snapshot on accepted start, one channel per RUN cycle, single DONE cycle.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        mode_d   = mode_q;
        mask_d   = mask_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d  = mode_e'(mode);
                    mask_d  = ch_mask;
                    a_d     = op_a;
                    b_d     = op_b;
                    ovf_d   = '0;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (mask_q[idx_q]) begin
                    result_d[idx_q*WIDTH +: WIDTH] = lane_res;
                    ovf_d[idx_q]                   = lane_ovf;
                end
                // Masked channels still spend their cycle so latency never varies.
                if (idx_q == IdxW'(N_CH - 1)) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous reset that also aborts a run.
    always_ff @(posedge okClk) begin
        if (reset) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            mode_q   <= ModeAdd;
            mask_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            ovf_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            mode_q   <= mode_d;
            mask_q   <= mask_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign result   = result_q;
    assign overflow = ovf_q;
    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);

endmodule

// File: tb/tb_ok_wire_arith.sv
// Self-checking bench for ok_wire_arith (N_CH=4, WIDTH=32), both wrap and saturating builds.
module tb_ok_wire_arith;

    localparam int N = 4;
    localparam int W = 32;
`ifdef OK_WIRE_ARITH_SAT_EN
    localparam bit Sat = 1'b1;
`else
    localparam bit Sat = 1'b0;
`endif
    localparam longint unsigned Full = 64'h1_0000_0000;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [1:0]     mode;
    logic [N-1:0]   mask;
    logic [N*W-1:0] op_a;
    logic [N*W-1:0] op_b;
    logic [N*W-1:0] result;
    logic [N-1:0]   overflow;
    logic           busy;
    logic           done;

    always #5 clk = ~clk;

    ok_wire_arith #(
        .N_CH  (N),
        .WIDTH (W)
    ) dut (
        .okClk    (clk),
        .reset    (reset),
        .start    (start),
        .mode     (mode),
        .ch_mask  (mask),
        .op_a     (op_a),
        .op_b     (op_b),
        .result   (result),
        .overflow (overflow),
        .busy     (busy),
        .done     (done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] m_res [N];
    logic [N-1:0] m_ovf;

    typedef struct {
        logic [1:0]     md;
        logic [N-1:0]   mk;
        logic [N*W-1:0] a;
        logic [N*W-1:0] b;
        logic [N*W-1:0] exp_wrap;
        logic [N*W-1:0] exp_sat;
        logic [N-1:0]   ovf;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) m_res[k] = '0;
        m_ovf = '0;
    endtask

    // Reference: unsigned arithmetic on 64-bit integers, clamp or wrap to 32 bits.
    task automatic model_op(input logic [1:0] md, input logic [N-1:0] mk,
                            input logic [N*W-1:0] a, input logic [N*W-1:0] b);
        longint unsigned x, y, s;
        bit ov;
        m_ovf = '0;
        for (int k = 0; k < N; k++) begin
            if (mk[k]) begin
                x = longint'(a[k*W +: W]);
                y = longint'(b[k*W +: W]);
                ov = 1'b0;
                case (md)
                    2'd0: begin s = x + y; ov = (s >= Full); end
                    2'd1: begin ov = (x < y); s = ov ? (x + Full - y) : (x - y); end
                    2'd2: begin s = longint'(m_res[k]) + x; ov = (s >= Full); end
                    default: begin s = x; ov = 1'b0; end
                endcase
                if (ov && Sat) s = (md == 2'd1) ? 64'd0 : Full - 1;
                m_res[k] = s[W-1:0];
                m_ovf[k] = ov;
            end
        end
    endtask

    function automatic logic [N*W-1:0] model_packed();
        return {m_res[3], m_res[2], m_res[1], m_res[0]};
    endfunction

    function automatic logic [W-1:0] rand_word();
        case ($urandom_range(0, 3))
            0:       return W'($urandom_range(0, 15));
            1:       return 32'hFFFF_FFF0 | W'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Issue one operation from an idle negedge; returns at the first idle negedge after done.
    task automatic run_op(input logic [1:0] md, input logic [N-1:0] mk,
                          input logic [N*W-1:0] a, input logic [N*W-1:0] b, input bit noise);
        int cyc;
        bit seen;
        mode  = md;
        mask  = mk;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        model_op(md, mk, a, b);
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (noise) begin
                start = 1'($urandom_range(0, 1));
                op_a  = {$urandom, $urandom, $urandom, $urandom};
                op_b  = {$urandom, $urandom, $urandom, $urandom};
                mode  = 2'($urandom_range(0, 3));
                mask  = 4'($urandom_range(0, 15));
            end else begin
                start = 1'b0;
            end
            check("busy_run", busy, 1);
            if (done) begin
                seen = 1'b1;
                check("done_latency", cyc, 5);
                check("result", result, model_packed());
                check("overflow", overflow, m_ovf);
            end
        end
        if (!seen) check("done_timeout", cyc, 5);
        @(negedge clk);
        start = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("result_hold", result, model_packed());
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int done_cnt;
        logic [N*W-1:0] ra, rb;

        // ch packing: {ch3, ch2, ch1, ch0}
        tbl[0] = '{md: 2'd0, mk: 4'b0001,
                   a: {32'h11, 32'h11, 32'h11, 32'd5}, b: {32'h22, 32'h22, 32'h22, 32'd7},
                   exp_wrap: {32'd0, 32'd0, 32'd0, 32'd12},
                   exp_sat:  {32'd0, 32'd0, 32'd0, 32'd12}, ovf: 4'b0000};
        tbl[1] = '{md: 2'd1, mk: 4'b0100,
                   a: {32'h11, 32'd3, 32'h11, 32'h11}, b: {32'h22, 32'd5, 32'h22, 32'h22},
                   exp_wrap: {32'd0, 32'hFFFF_FFFE, 32'd0, 32'd12},
                   exp_sat:  {32'd0, 32'd0, 32'd0, 32'd12}, ovf: 4'b0100};
        tbl[2] = '{md: 2'd3, mk: 4'b0010,
                   a: {32'd0, 32'd0, 32'hFFFF_FFF0, 32'd0}, b: {4{32'hFFFF_FFFF}},
                   exp_wrap: {32'd0, 32'hFFFF_FFFE, 32'hFFFF_FFF0, 32'd12},
                   exp_sat:  {32'd0, 32'd0, 32'hFFFF_FFF0, 32'd12}, ovf: 4'b0000};
        tbl[3] = '{md: 2'd2, mk: 4'b0010,
                   a: {32'd0, 32'd0, 32'h20, 32'd0}, b: {4{32'h5555_5555}},
                   exp_wrap: {32'd0, 32'hFFFF_FFFE, 32'h10, 32'd12},
                   exp_sat:  {32'd0, 32'd0, 32'hFFFF_FFFF, 32'd12}, ovf: 4'b0010};
        tbl[4] = '{md: 2'd0, mk: 4'b1111,
                   a: {32'd10, 32'h8000_0000, 32'd1, 32'hFFFF_FFFF},
                   b: {32'd20, 32'h8000_0000, 32'd2, 32'd1},
                   exp_wrap: {32'd30, 32'd0, 32'd3, 32'd0},
                   exp_sat:  {32'd30, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF}, ovf: 4'b0101};
        tbl[5] = '{md: 2'd1, mk: 4'b1010,
                   a: {32'd5, 32'd1, 32'd10, 32'd1}, b: {32'd5, 32'd9, 32'd3, 32'd9},
                   exp_wrap: {32'd0, 32'd0, 32'd7, 32'd0},
                   exp_sat:  {32'd0, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFF}, ovf: 4'b0000};
        tbl[6] = '{md: 2'd3, mk: 4'b1111,
                   a: {32'd4, 32'd3, 32'd2, 32'd1}, b: {4{32'd9}},
                   exp_wrap: {32'd4, 32'd3, 32'd2, 32'd1},
                   exp_sat:  {32'd4, 32'd3, 32'd2, 32'd1}, ovf: 4'b0000};
        tbl[7] = '{md: 2'd2, mk: 4'b1111,
                   a: {32'hFFFF_FFFC, 32'd1, 32'd0, 32'hFFFF_FFFF}, b: {4{32'd7}},
                   exp_wrap: {32'd0, 32'd4, 32'd2, 32'd0},
                   exp_sat:  {32'hFFFF_FFFF, 32'd4, 32'd2, 32'hFFFF_FFFF}, ovf: 4'b1001};

        // Reset held two cycles, then released: idle, no done.
        reset = 1'b1;
        start = 1'b0;
        mode  = 2'd0;
        mask  = '0;
        op_a  = '0;
        op_b  = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_result", result, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_busy", busy, 0);
            check("post_rst_done", done, 0);
        end

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].md, tbl[i].mk, tbl[i].a, tbl[i].b, 1'b0);
            check($sformatf("tbl%0d_result", i), result, Sat ? tbl[i].exp_sat : tbl[i].exp_wrap);
            check($sformatf("tbl%0d_overflow", i), overflow, tbl[i].ovf);
        end

        // Handshake: starts in cycles 0, 2, 5 give one done at cycle 5; start at 6 is accepted.
        mode  = 2'd0;
        mask  = 4'b0001;
        op_a  = {32'd0, 32'd0, 32'd0, 32'd100};
        op_b  = {32'd0, 32'd0, 32'd0, 32'd1};
        start = 1'b1;
        model_op(mode, mask, op_a, op_b);
        done_cnt = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start = (c == 2 || c == 5 || c == 6);
            if (c == 2) op_a = {4{32'hFFFF_FFFF}};
            if (done) begin
                done_cnt++;
                check("hs_done_cycle", c, (done_cnt == 1) ? 5 : 11);
                check("hs_result", result, model_packed());
                check("hs_overflow", overflow, m_ovf);
            end
            if (c == 6) model_op(mode, mask, op_a, op_b);
            if (c == 7) check("hs_second_busy", busy, 1);
        end
        start = 1'b0;
        check("hs_done_count", done_cnt, 2);
        check("hs_idle_busy", busy, 0);

        // Reset in cycle 3 of a run aborts it without a done pulse.
        mode  = 2'd3;
        mask  = 4'b1111;
        op_a  = {4{32'hA5A5_A5A5}};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_pre_reset", result[31:0], 32'hA5A5_A5A5);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        check("mid_busy", busy, 0);
        check("mid_done", done, 0);
        check("mid_result", result, 0);
        check("mid_overflow", overflow, 0);
        done_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("mid_no_done", done_cnt, 0);
        run_op(2'd0, 4'b1111, {32'd1, 32'd2, 32'd3, 32'd4}, {32'd10, 32'd20, 32'd30, 32'd40}, 1'b0);

        // Reset and start together: reset wins.
        model_reset();
        reset = 1'b1;
        start = 1'b1;
        mode  = 2'd3;
        mask  = 4'b1111;
        op_a  = {4{32'h1234_5678}};
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        done_cnt = 0;
        check("rs_busy", busy, 0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done || busy) done_cnt++;
        end
        check("rs_no_run", done_cnt, 0);
        check("rs_result", result, model_packed());

        // Randomized operations with start/operand noise while busy.
        for (int i = 0; i < 40; i++) begin
            ra = {rand_word(), rand_word(), rand_word(), rand_word()};
            rb = {rand_word(), rand_word(), rand_word(), rand_word()};
            run_op(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), ra, rb, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
